// File: rtl/csa_pipe_approx.sv
// -----------------------------------------------------------------------------
// csa_pipe_approx
//
// Pipelined carry-select adder with an optional approximate low-order region.
// The WIDTH-bit addition is split into NBLK = WIDTH/BLK slices, one slice per
// pipeline stage.  Each stage forms the slice sum for both possible carry-ins
// and keeps the one selected by the carry registered in the previous stage.
// Operand bits for later slices ride along the pipeline so that every stage
// works on its part of the same operand set.  Each stage's operand register
// only keeps the bits that later stages still need.
//
// In approximate mode the low APPROX_K sum bits are A|B, cin is ignored and
// the carry into bit APPROX_K is A[APPROX_K-1] & B[APPROX_K-1].  The upper bits
// and cout are the exact sum of the upper operand bits with that carry.
//
// Flow control is a single global advance: the whole pipeline moves when the
// output is empty or being taken, and freezes otherwise.
//
// Parameters
//   WIDTH     operand / sum width (multiple of BLK)
//   BLK       carry-select slice width
//   APPROX_K  number of approximate low sum bits (0..WIDTH-1)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   A, B        operands
//   cin         carry-in (ignored in approximate mode when APPROX_K > 0)
//   approx_en   approximate mode for this operand set
//   in_valid    operand set present
//   in_ready    operand set can be accepted this cycle
//   S, cout     sum and carry-out
//   out_approx  result was produced in approximate mode
//   out_valid   S, cout, out_approx hold a result
//   out_ready   downstream accepts the result
// -----------------------------------------------------------------------------
module csa_pipe_approx #(
    parameter int WIDTH    = 32,
    parameter int BLK      = 8,
    parameter int APPROX_K = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             approx_en,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             out_approx,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NBLK = WIDTH / BLK;

    logic advance;

    // Ripple sum of one slice for a given carry-in.  Bits below APPROX_K in
    // approximate mode produce a|b and pass on a&b as their carry, so the
    // carry leaving bit APPROX_K-1 is exactly A[K-1]&B[K-1] and the incoming
    // carry never reaches the exact region.
    function automatic logic [BLK:0] slice_add(
        input logic [BLK-1:0] a,
        input logic [BLK-1:0] b,
        input logic           c_in,
        input logic           approx,
        input int             base
    );
        logic [BLK-1:0] s;
        logic           c;
        s = '0;
        c = c_in;
        for (int j = 0; j < BLK; j++) begin
            if (approx && ((base + j) < APPROX_K)) begin
                s[j] = a[j] | b[j];
                c    = a[j] & b[j];
            end else begin
                s[j] = a[j] ^ b[j] ^ c;
                c    = (a[j] & b[j]) | (c & (a[j] ^ b[j]));
            end
        end
        return {c, s};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_stage
            localparam int LO  = BLK * gi;
            localparam int SW  = BLK * (gi + 1);
            localparam int REM = WIDTH - SW;

            // Inputs seen by this stage
            logic [BLK-1:0] a_sl;
            logic [BLK-1:0] b_sl;
            logic           c_sel;
            logic           valid_d;
            logic           approx_d;
            logic [SW-1:0]  sum_d;

            // Both carry-select candidates and the chosen one
            logic [BLK:0]   res0;
            logic [BLK:0]   res1;
            logic [BLK:0]   res_sel;

            logic           valid_q;
            logic           approx_q;
            logic           carry_q;
            logic [SW-1:0]  sum_q;

            if (gi == 0) begin : g_src
                assign a_sl     = A[BLK-1:0];
                assign b_sl     = B[BLK-1:0];
                assign c_sel    = cin;
                assign valid_d  = in_valid;     // in_valid=0 injects a bubble
                assign approx_d = approx_en;
                assign sum_d    = res_sel[BLK-1:0];
            end else begin : g_src
                assign a_sl     = g_stage[gi-1].g_ops.a_rem_q[BLK-1:0];
                assign b_sl     = g_stage[gi-1].g_ops.b_rem_q[BLK-1:0];
                assign c_sel    = g_stage[gi-1].carry_q;
                assign valid_d  = g_stage[gi-1].valid_q;
                assign approx_d = g_stage[gi-1].approx_q;
                assign sum_d    = {res_sel[BLK-1:0], g_stage[gi-1].sum_q};
            end

            assign res0    = slice_add(a_sl, b_sl, 1'b0, approx_d, LO);
            assign res1    = slice_add(a_sl, b_sl, 1'b1, approx_d, LO);
            assign res_sel = c_sel ? res1 : res0;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q  <= 1'b0;
                    approx_q <= 1'b0;
                    carry_q  <= 1'b0;
                    sum_q    <= '0;
                end else if (advance) begin
                    valid_q  <= valid_d;
                    approx_q <= approx_d;
                    carry_q  <= res_sel[BLK];
                    sum_q    <= sum_d;
                end
            end

            // Operand bits still needed by the stages after this one
            if (REM > 0) begin : g_ops
                logic [REM-1:0] a_rem_d;
                logic [REM-1:0] b_rem_d;
                logic [REM-1:0] a_rem_q;
                logic [REM-1:0] b_rem_q;

                if (gi == 0) begin : g_from_port
                    assign a_rem_d = A[WIDTH-1:BLK];
                    assign b_rem_d = B[WIDTH-1:BLK];
                end else begin : g_from_prev
                    assign a_rem_d = g_stage[gi-1].g_ops.a_rem_q[REM+BLK-1:BLK];
                    assign b_rem_d = g_stage[gi-1].g_ops.b_rem_q[REM+BLK-1:BLK];
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_rem_q <= '0;
                        b_rem_q <= '0;
                    end else if (advance) begin
                        a_rem_q <= a_rem_d;
                        b_rem_q <= b_rem_d;
                    end
                end
            end
        end
    endgenerate

    assign out_valid  = g_stage[NBLK-1].valid_q;
    assign out_approx = g_stage[NBLK-1].approx_q;
    assign cout       = g_stage[NBLK-1].carry_q;
    assign S          = g_stage[NBLK-1].sum_q;

    // The pipeline only moves when the output slot is free or being drained.
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

endmodule

// File: tb/tb_csa_pipe_approx.sv
module tb_csa_pipe_approx;

    localparam int WIDTH = 16;
    localparam int BLK   = 4;
    localparam int K     = 4;
    localparam int NBLK  = WIDTH / BLK;
    localparam int KM1   = (K > 0) ? K - 1 : 0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             cin = 1'b0;
    logic             approx_en = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             out_approx;
    logic             out_valid;

    always #5 clk = ~clk;

    csa_pipe_approx #(.WIDTH(WIDTH), .BLK(BLK), .APPROX_K(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .cin        (cin),
        .approx_en  (approx_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .S          (S),
        .cout       (cout),
        .out_approx (out_approx),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit lat_check  = 1'b0;
    bit stall_prev = 1'b0;
    logic [18:0] held;
    logic [17:0] exp_q[$];
    int          acc_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: {out_approx, cout, S} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic x);
        int unsigned ua, ub, r, mask, carry;
        ua = a;
        ub = b;
        if (x && K > 0) begin
            mask  = (32'd1 << K) - 1;
            carry = ((ua >> KM1) & (ub >> KM1)) & 1;
            r = ((((ua >> K) + (ub >> K) + carry) << K) | ((ua | ub) & mask));
        end else begin
            r = ua + ub + c;
        end
        return {x, r[16:0]};
    endfunction

    // One clock cycle: drive inputs after the falling edge, then observe.
    task automatic step(input bit iv, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic x, input bit ordy, output bit took);
        logic [17:0] e;
        int          acc;
        @(negedge clk);
        out_ready = ordy;
        in_valid  = iv;
        A = a;
        B = b;
        cin = c;
        approx_en = x;
        #1;
        if (stall_prev)
            check_eq("hold", {out_valid, out_approx, cout, S}, held);
        check_eq("in_ready", in_ready, out_ready || !out_valid);
        if (exp_q.size() == 0)
            check_eq("spurious_valid", out_valid, 1'b0);
        if (out_valid && out_ready && exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            acc = acc_q.pop_front();
            check_eq("result", {out_approx, cout, S}, e);
            if (lat_check)
                check_eq("latency", cyc - acc, NBLK);
            $display("OUT cyc=%0d acc=%0d S=%h cout=%b approx=%b exp=%h",
                     cyc, acc, S, cout, out_approx, e);
        end
        stall_prev = out_valid && !out_ready;
        held = {out_valid, out_approx, cout, S};
        took = iv && in_ready;
        if (took) begin
            exp_q.push_back(model(a, b, c, x));
            acc_q.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic x);
        bit took;
        took = 1'b0;
        for (int n = 0; n < 100 && !took; n++)
            step(1'b1, a, b, c, x, 1'b1, took);
        check_eq("send_accepted", took, 1'b1);
    endtask

    task automatic drain();
        bit took;
        for (int n = 0; n < 40 && exp_q.size() > 0; n++)
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, took);
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   took;
        int   sent;
        int   accepted;
        int   n;
        logic [15:0] ra, rb;

        // Reset state
        #12;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_S", S, 16'h0);
        check_eq("rst_cout", cout, 1'b0);
        check_eq("rst_out_approx", out_approx, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", in_ready, 1'b1);

        // Directed vectors, isolated, with latency checked
        lat_check = 1'b1;
        send(16'h0000, 16'h0000, 1'b0, 1'b0); drain();
        send(16'hAA55, 16'hFFFF, 1'b1, 1'b0); drain();
        send(16'hAA05, 16'hFF04, 1'b1, 1'b0); drain();
        send(16'hAA05, 16'hFF04, 1'b1, 1'b1); drain();
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1); drain();
        send(16'h0008, 16'h0008, 1'b0, 1'b1); drain();
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0); drain();

        // Back-to-back stream of 8 sets: each must arrive exactly NBLK later
        for (int i = 0; i < 8; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        drain();

        // Stream with a 3-cycle downstream stall while results are pending
        lat_check = 1'b0;
        sent = 0;
        for (int c = 0; c < 40 && (sent < 8 || exp_q.size() > 0); c++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            step(sent < 8, ra, rb, 1'($urandom), 1'b0, !(c >= 5 && c <= 7), took);
            if (c >= 5 && c <= 7)
                check_eq("stall_in_ready", in_ready, 1'b0);
            if (took) sent++;
        end
        check_eq("stall_stream_sent", sent, 8);
        drain();

        // Reset with sets in flight: nothing stale may come out afterwards
        for (int i = 0; i < 4; i++)
            send(16'($urandom), 16'($urandom), 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, took);
        check_eq("pre_rst_out_valid", out_valid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", out_valid, 1'b0);
        check_eq("mid_rst_S", S, 16'h0);
        check_eq("mid_rst_cout", cout, 1'b0);
        check_eq("mid_rst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        acc_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++)
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, took);
        lat_check = 1'b1;
        send(16'h1234, 16'h4321, 1'b1, 1'b0);
        drain();
        lat_check = 1'b0;

        // Random exact-mode traffic with random valid/ready
        accepted = 0;
        n = 0;
        while (accepted < 10000 && n < 60000) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0,
                 $urandom_range(0, 3) != 0, took);
            if (took) accepted++;
            n++;
        end
        check_eq("rand_exact_count", accepted >= 10000, 1'b1);

        // Random mixed-mode traffic
        accepted = 0;
        n = 0;
        while (accepted < 1000 && n < 10000) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
                 1'($urandom), $urandom_range(0, 3) != 0, took);
            if (took) accepted++;
            n++;
        end
        check_eq("rand_mixed_count", accepted >= 1000, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
